// File: rtl/mpu_sequencer.sv
// ---------------------------------------------------------------------------
// mpu_sequencer
//
// Instruction sequencer for the MPU. Fetches six instruction bytes from the
// program memory into a 48-bit window, lets the external decoder/ALU look at
// that window for one EXEC cycle, and then advances or redirects the program
// counter. Register-load instructions produce a one-cycle write strobe;
// memory-load instructions run a req/ack handshake before the pc advances.
//
// Ports
//   sys_clk     in   1   clock, rising edge
//   sys_rst     in   1   synchronous active-high reset
//   start       in   1   begin execution at pc 0 (ignored unless idle)
//   busy        out  1   high while a program is running
//   done        out  1   one-cycle pulse after a halt or error
//   error       out  1   sticky decode error, cleared by start
//   pc          out  16  program counter (byte address)
//   m_addr      out  16  program memory byte address
//   m_data      in   8   program memory read data (1-cycle latency)
//   i           out  48  instruction window, byte at pc in i[7:0]
//   isize       in   16  decoder instruction size in bytes
//   op          in   4   decoder opcode
//   jaddr       in   16  decoder jump address
//   imm         in   32  decoder immediate
//   err         in   1   decoder error
//   alu_cond    in   1   ALU condition for ops 1/2/3 (1 = fall through)
//   w_en        out  1   register write strobe (combinational with EXEC)
//   w_addr      out  8   register byte selector
//   w_size      out  2   operand size
//   w_data      out  32  immediate zero-extended to w_size
//   mload_req   out  1   memory-load request (level)
//   mload_addr  out  8   memory-load register byte selector
//   mload_ack   in   1   memory-load completion pulse
// ---------------------------------------------------------------------------
module mpu_sequencer (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] pc,
   output logic [15:0] m_addr,
   input  logic [7:0]  m_data,
   output logic [47:0] i,
   input  logic [15:0] isize,
   input  logic [3:0]  op,
   input  logic [15:0] jaddr,
   input  logic [31:0] imm,
   input  logic        err,
   input  logic        alu_cond,
   output logic        w_en,
   output logic [7:0]  w_addr,
   output logic [1:0]  w_size,
   output logic [31:0] w_data,
   output logic        mload_req,
   output logic [7:0]  mload_addr,
   input  logic        mload_ack
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_MLOAD = 2'd3;

   // Last fetch counter value; the byte requested at k=5 lands during k=6.
   localparam logic [2:0] K_LAST   = 3'd6;

   logic [1:0]  r_state;
   logic [2:0]  r_k;
   logic [15:0] r_pc;
   logic [15:0] r_m_addr;
   logic [47:0] r_i;
   logic        r_busy;
   logic        r_done;
   logic        r_error;
   logic        r_mload_req;
   logic [7:0]  r_mload_addr;

   logic        w_in_exec;
   logic [15:0] w_pc_seq;
   logic [15:0] w_pc_next;
   logic        w_is_halt;
   logic        w_is_err;
   logic        w_is_flow;
   logic        w_is_write;
   logic        w_is_mload;
   logic [31:0] w_imm_ext;

   assign w_in_exec = (r_state == ST_EXEC);

   // Sequential successor; 16-bit addition wraps naturally.
   assign w_pc_seq  = r_pc + isize;

   // EXEC decision: halt beats decoder error, which beats opcode dispatch.
   always_comb begin
      w_is_halt  = 1'b0;
      w_is_err   = 1'b0;
      w_is_flow  = 1'b0;
      w_is_write = 1'b0;
      w_is_mload = 1'b0;
      w_pc_next  = r_pc;
      if (r_i[7:0] == 8'h00) begin
         w_is_halt = 1'b1;
      end else if (err) begin
         w_is_err = 1'b1;
      end else begin
         case (op)
            4'h1, 4'h2, 4'h3: begin
               // A false condition takes the branch.
               w_is_flow = 1'b1;
               w_pc_next = alu_cond ? w_pc_seq : jaddr;
            end
            4'hf: begin
               w_is_flow = 1'b1;
               w_pc_next = jaddr;
            end
            4'he: begin
               w_is_flow  = 1'b1;
               w_is_write = 1'b1;
               w_pc_next  = w_pc_seq;
            end
            4'hd: begin
               w_is_mload = 1'b1;
            end
            default: begin
               // An opcode the sequencer cannot act on is stopped as an
               // error rather than silently skipped.
               w_is_err = 1'b1;
            end
         endcase
      end
   end

   // Zero-extend the immediate to the operand size held in i[1:0].
   always_comb begin
      w_imm_ext = 32'h0000_0000;
      case (r_i[1:0])
         2'd0:    w_imm_ext = {24'h00_0000, imm[7:0]};
         2'd1:    w_imm_ext = {16'h0000, imm[15:0]};
         default: w_imm_ext = imm;
      endcase
   end

   // Main state machine, fetch window, pc and handshake registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state      <= ST_IDLE;
         r_k          <= 3'd0;
         r_pc         <= 16'h0000;
         r_m_addr     <= 16'h0000;
         r_i          <= 48'h0000_0000_0000;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_mload_req  <= 1'b0;
         r_mload_addr <= 8'h00;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_FETCH;
                  r_k      <= 3'd0;
                  r_pc     <= 16'h0000;
                  r_m_addr <= 16'h0000;
                  r_error  <= 1'b0;
                  r_busy   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               // Memory answers one cycle late, so slot k-1 fills at step k.
               if (r_k != 3'd0) begin
                  r_i[{r_k - 3'd1, 3'd0} +: 8] <= m_data;
               end else begin
                  r_i <= r_i;
               end
               r_m_addr <= r_m_addr + 16'd1;
               if (r_k == K_LAST) begin
                  r_state <= ST_EXEC;
                  r_k     <= 3'd0;
               end else begin
                  r_k <= r_k + 3'd1;
               end
            end
            ST_EXEC: begin
               if (w_is_halt || w_is_err) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_error <= w_is_err;
               end else if (w_is_mload) begin
                  r_state      <= ST_MLOAD;
                  r_mload_req  <= 1'b1;
                  r_mload_addr <= r_i[15:8];
               end else if (w_is_flow) begin
                  r_state  <= ST_FETCH;
                  r_k      <= 3'd0;
                  r_pc     <= w_pc_next;
                  r_m_addr <= w_pc_next;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_MLOAD: begin
               // Ack is honoured from the first MLOAD cycle onward.
               if (mload_ack) begin
                  r_state     <= ST_FETCH;
                  r_k         <= 3'd0;
                  r_mload_req <= 1'b0;
                  r_pc        <= w_pc_seq;
                  r_m_addr    <= w_pc_seq;
               end else begin
                  r_mload_req <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign pc         = r_pc;
   assign m_addr     = r_m_addr;
   assign i          = r_i;
   assign mload_req  = r_mload_req;
   assign mload_addr = r_mload_addr;

   // Write port is only meaningful in EXEC; held at zero otherwise.
   assign w_en   = w_in_exec & w_is_write;
   assign w_addr = w_in_exec ? r_i[15:8] : 8'h00;
   assign w_size = w_in_exec ? r_i[1:0]  : 2'd0;
   assign w_data = w_in_exec ? w_imm_ext : 32'h0000_0000;

endmodule
